row_line_loader: RTL

- Byte-stream command decoder between the image-data UART receiver and framebuffer RAM port A.
- Parses ASCII row-load lines of the form 'L' + two decimal row digits + hex pixel bytes + LF.
- Emits single-cycle byte writes at address row*BYTES_PER_ROW + byte_index.
- Reports per-line success or error to the debugger.

---
 rtl/row_line_loader_pkg.sv | 21 ++
 rtl/row_line_loader_ascii_hex_decode.sv | 25 ++
 rtl/row_line_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/row_line_loader_pkg.sv
// Shared types and constants for the row-load line parser.
package row_line_loader_pkg;

   localparam int unsigned ROWS_DEFAULT          = 32;
   localparam int unsigned BYTES_PER_ROW_DEFAULT = 128;

   localparam logic [7:0] CHAR_L  = 8'h4C;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;

   typedef enum logic [2:0] {
      StIdle,
      StRowHi,
      StRowLo,
      StDataHi,
      StDataLo,
      StExpectEol,
      StDiscard
   } state_e;

endpackage

// File: rtl/row_line_loader_ascii_hex_decode.sv
// Combinational ASCII classifier: decimal digit, hex digit and nibble value.
module row_line_loader_ascii_hex_decode (
   input  logic [7:0] char_i,
   output logic       is_dec_o,
   output logic       is_hex_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      is_dec_o = 1'b0;
      is_hex_o = 1'b0;
      nibble_o = 4'h0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         is_dec_o = 1'b1;
         is_hex_o = 1'b1;
         nibble_o = char_i[3:0];
      end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                   (char_i >= 8'h61 && char_i <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
         is_hex_o = 1'b1;
         nibble_o = char_i[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/row_line_loader.sv
// Parses "L<dd><hex pairs>\n" lines from the UART and writes the bytes into framebuffer port A.
module row_line_loader
   import row_line_loader_pkg::*;
#(
   parameter int unsigned                ROWS          = ROWS_DEFAULT,
   parameter int unsigned                BYTES_PER_ROW = BYTES_PER_ROW_DEFAULT,
   parameter int unsigned                ADDR_WIDTH    = 12,
   parameter int unsigned                TIMEOUT_WIDTH = 20,
   parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_TICKS = 20'd727273
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [7:0]            ram_data_out,
   output logic                  ram_write_enable,
   output logic                  ram_clk_enable,
   output logic                  line_done,
   output logic                  line_error,
   output logic                  busy,
   output logic [7:0]            num_lines_ok
);

   localparam int unsigned IdxWidth = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;

   state_e                  state_q, state_d;
   logic [3:0]              row_hi_q, row_hi_d;
   logic [6:0]              row_q, row_d;
   logic [3:0]              nib_hi_q, nib_hi_d;
   logic [IdxWidth-1:0]     idx_q, idx_d;
   logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              data_q, data_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [7:0]              lines_q, lines_d;

   logic       is_dec, is_hex;
   logic [3:0] nibble;
   logic       byte_seen;
   logic [6:0] row_val;

   row_line_loader_ascii_hex_decode u_decode (
      .char_i   (rx_data),
      .is_dec_o (is_dec),
      .is_hex_o (is_hex),
      .nibble_o (nibble)
   );

   assign row_val = 7'(row_hi_q) * 7'd10 + 7'(nibble);

   always_comb begin
      state_d  = state_q;
      row_hi_d = row_hi_q;
      row_d    = row_q;
      nib_hi_d = nib_hi_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      lines_d  = lines_q;

      // CR is transparent: it neither advances the parser nor feeds the timeout
      byte_seen = rx_valid && (rx_data != CHAR_CR);

      if (state_q == StIdle) begin
         tmo_d = '0;
      end

      if (byte_seen) begin
         tmo_d = '0;
         if (rx_data == CHAR_L) begin
            state_d = StRowHi;
            err_d   = (state_q != StIdle) && (state_q != StDiscard);
         end else if (rx_data == CHAR_LF) begin
            state_d = StIdle;
            err_d   = (state_q == StRowHi) || (state_q == StRowLo) ||
                      (state_q == StDataHi) || (state_q == StDataLo);
            if (state_q == StExpectEol) begin
               done_d  = 1'b1;
               lines_d = lines_q + 8'd1;
            end
         end else begin
            unique case (state_q)
               StIdle, StDiscard: ;
               StRowHi: begin
                  if (is_dec) begin
                     row_hi_d = nibble;
                     state_d  = StRowLo;
                  end else begin
                     state_d = StDiscard;
                     err_d   = 1'b1;
                  end
               end
               StRowLo: begin
                  if (is_dec && (32'(row_val) < ROWS)) begin
                     row_d   = row_val;
                     idx_d   = '0;
                     state_d = StDataHi;
                  end else begin
                     state_d = StDiscard;
                     err_d   = 1'b1;
                  end
               end
               StDataHi: begin
                  if (is_hex) begin
                     nib_hi_d = nibble;
                     state_d  = StDataLo;
                  end else begin
                     state_d = StDiscard;
                     err_d   = 1'b1;
                  end
               end
               StDataLo: begin
                  if (is_hex) begin
                     we_d   = 1'b1;
                     data_d = {nib_hi_q, nibble};
                     addr_d = ADDR_WIDTH'(32'(row_q) * BYTES_PER_ROW + 32'(idx_q));
                     idx_d  = idx_q + IdxWidth'(1);
                     if (idx_q == IdxWidth'(BYTES_PER_ROW - 1)) begin
                        state_d = StExpectEol;
                     end else begin
                        state_d = StDataHi;
                     end
                  end else begin
                     state_d = StDiscard;
                     err_d   = 1'b1;
                  end
               end
               StExpectEol: begin
                  state_d = StDiscard;
                  err_d   = 1'b1;
               end
               default: state_d = StIdle;
            endcase
         end
      end else if (state_q != StIdle) begin
         if (tmo_q == TIMEOUT_TICKS - TIMEOUT_WIDTH'(1)) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_d   = (state_q != StDiscard);
         end else begin
            tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_q  <= StIdle;
         row_hi_q <= '0;
         row_q    <= '0;
         nib_hi_q <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         lines_q  <= '0;
      end else begin
         state_q  <= state_d;
         row_hi_q <= row_hi_d;
         row_q    <= row_d;
         nib_hi_q <= nib_hi_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
         lines_q  <= lines_d;
      end
   end

   assign ram_address      = addr_q;
   assign ram_data_out     = data_q;
   assign ram_write_enable = we_q;
   assign ram_clk_enable   = we_q;
   assign line_done        = done_q;
   assign line_error       = err_q;
   assign busy             = (state_q != StIdle);
   assign num_lines_ok     = lines_q;

endmodule
